apuf_crp_controller: RTL

Challenge–response driver for the 22-stage arbiter PUF. It generates challenges from an LFSR and applies them to the PUF challenge bus. It launches the race by raising both PUF path inputs together, then samples and synchronises the arbiter flip-flop output. Each challenge/response pair (CRP) is streamed out over a valid/ready interface to the enrolment/authentication logic.

---
 rtl/apuf_crp_controller.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/apuf_crp_controller.sv
// Challenge/response driver for a 22-stage arbiter PUF. It steps an LFSR challenge,
// launches the race, samples the arbiter output and streams CRPs over valid/ready.
module apuf_crp_controller #(
  parameter int unsigned       CHAL_W = 22,
  parameter logic [CHAL_W-1:0] TAPS   = 22'h30_0000,
  parameter int unsigned       SETTLE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [15:0]       num_crps,
  input  logic [CHAL_W-1:0] seed,
  output logic              apuf_x,
  output logic              apuf_y,
  output logic [CHAL_W-1:0] apuf_chal,
  input  logic              apuf_q,
  output logic              crp_valid,
  input  logic              crp_ready,
  output logic [CHAL_W-1:0] crp_chal,
  output logic              crp_resp,
  output logic              busy,
  output logic              done
);

  // FIRE lasts SETTLE+2 cycles, so the wait counter needs one bit beyond 8 when SETTLE=255.
  localparam logic [8:0] SETTLE_LAST = 9'(SETTLE - 1);
  localparam logic [8:0] FIRE_LAST   = 9'(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_FIRE,
    S_EMIT,
    S_RELAX,
    S_DONE
  } state_t;

  state_t              state, state_nx;
  logic [CHAL_W-1:0]   lfsr, lfsr_nx, lfsr_adv;
  logic [15:0]         remaining, remaining_nx;
  logic [8:0]          wait_cnt, wait_nx;
  logic                launch, launch_nx;
  logic [CHAL_W-1:0]   apuf_chal_nx, crp_chal_nx;
  logic                crp_valid_nx, crp_resp_nx, busy_nx, done_nx;
  logic                q_meta, q_s;

  // apuf_q comes straight off the arbiter flop with no relation to clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_meta <= 1'b0;
      q_s    <= 1'b0;
    end else begin
      q_meta <= apuf_q;
      q_s    <= q_meta;
    end
  end

  assign lfsr_adv = {lfsr[CHAL_W-2:0], ^(lfsr & TAPS)};

  // One launch register feeds both paths so X and Y always toggle on the same edge.
  assign apuf_x = launch;
  assign apuf_y = launch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      lfsr      <= CHAL_W'(1);
      remaining <= 16'd0;
      wait_cnt  <= 9'd0;
      launch    <= 1'b0;
      apuf_chal <= '0;
      crp_valid <= 1'b0;
      crp_chal  <= '0;
      crp_resp  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      lfsr      <= lfsr_nx;
      remaining <= remaining_nx;
      wait_cnt  <= wait_nx;
      launch    <= launch_nx;
      apuf_chal <= apuf_chal_nx;
      crp_valid <= crp_valid_nx;
      crp_chal  <= crp_chal_nx;
      crp_resp  <= crp_resp_nx;
      busy      <= busy_nx;
      done      <= done_nx;
    end
  end

  always_comb begin
    state_nx     = state;
    lfsr_nx      = lfsr;
    remaining_nx = remaining;
    wait_nx      = wait_cnt;
    launch_nx    = launch;
    apuf_chal_nx = apuf_chal;
    crp_valid_nx = crp_valid;
    crp_chal_nx  = crp_chal;
    crp_resp_nx  = crp_resp;
    busy_nx      = busy;
    done_nx      = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          lfsr_nx      = (seed == '0) ? CHAL_W'(1) : seed;
          remaining_nx = num_crps;
          busy_nx      = 1'b1;
          state_nx     = (num_crps == 16'd0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        apuf_chal_nx = lfsr;
        launch_nx    = 1'b0;
        wait_nx      = SETTLE_LAST;
        state_nx     = S_SETTLE;
      end
      S_SETTLE: begin
        if (wait_cnt == 9'd0) begin
          launch_nx = 1'b1;
          wait_nx   = FIRE_LAST;
          state_nx  = S_FIRE;
        end else begin
          wait_nx = wait_cnt - 9'd1;
        end
      end
      S_FIRE: begin
        if (wait_cnt == 9'd0) begin
          crp_resp_nx  = q_s;
          crp_chal_nx  = apuf_chal;
          crp_valid_nx = 1'b1;
          state_nx     = S_EMIT;
        end else begin
          wait_nx = wait_cnt - 9'd1;
        end
      end
      // The launch stays high through any stall; the race is never re-fired.
      S_EMIT: begin
        if (crp_ready) begin
          crp_valid_nx = 1'b0;
          remaining_nx = remaining - 16'd1;
          lfsr_nx      = lfsr_adv;
          launch_nx    = 1'b0;
          wait_nx      = SETTLE_LAST;
          state_nx     = S_RELAX;
        end
      end
      S_RELAX: begin
        if (wait_cnt == 9'd0) begin
          state_nx = (remaining != 16'd0) ? S_LOAD : S_DONE;
        end else begin
          wait_nx = wait_cnt - 9'd1;
        end
      end
      S_DONE: begin
        done_nx  = 1'b1;
        busy_nx  = 1'b0;
        state_nx = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule
